// File: rtl/ghostbus_host_pkg.sv
// Shared encodings for the ghostbus byte host: FSM states, command byte fields,
// and the bit-width to byte-count helper.
package ghostbus_host_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        WSTB  = 3'd3,
        RSTB  = 3'd4,
        WAIT  = 3'd5,
        RESP  = 3'd6
    } state_t;

    localparam int CMD_RD_BIT  = 7;
    localparam int CMD_RSV_MSB = 6;
    localparam int CMD_RSV_LSB = 4;
    localparam int CMD_CNT_MSB = 3;
    localparam int CMD_CNT_LSB = 0;

    function automatic int width_to_bytes(input int width_bits);
        return width_bits / 8;
    endfunction

endpackage

// File: rtl/ghostbus_byte_serializer.sv
// Parallel-load DW-bit word, emitted as DW/8 bytes MSB first on a valid/ready port.
// Latency: first byte valid the cycle after load. Backpressure: holds tx_data while !tx_ready.
// Shift only advances on an accepted byte; done pulses with the final handshake.
module ghostbus_byte_serializer
    import ghostbus_host_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          gb_clk,
    input  logic          gb_rst,
    input  logic          load_vld,
    input  logic [DW-1:0] load_dat,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          done
);

    localparam int NB = width_to_bytes(DW);
    localparam int CW = $clog2(NB + 1);

    logic [DW-1:0] sr_q,  sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          act_q, act_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        act_d = act_q;
        done  = 1'b0;
        if (load_vld) begin
            sr_d  = load_dat;
            cnt_d = '0;
            act_d = 1'b1;
        end else if (act_q && tx_ready) begin
            sr_d  = sr_q << 8;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NB - 1)) begin
                act_d = 1'b0;
                done  = 1'b1;
            end
        end
    end

    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            act_q <= act_d;
        end
    end

    assign tx_data  = sr_q[DW-1 -: 8];
    assign tx_valid = act_q;

endmodule

// File: rtl/ghostbus_byte_host.sv
// Byte-stream command parser driving ghostbus write/read strobes; read data returned as bytes.
// Latency: strobe the cycle after the last frame byte; read capture RD_LAT cycles after gb_rstb.
// Backpressure: rx_ready low outside IDLE/ADDR/WDATA; RESP waits on tx_ready. Burst: GHOSTBUS_BYTE_HOST_BURST_EN.
module ghostbus_byte_host
    import ghostbus_host_pkg::*;
#(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic          gb_clk,
    input  logic          gb_rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    input  logic [DW-1:0] gb_rdata,
    output logic          gb_wen,
    output logic          gb_rstb,
    output logic          busy,
    output logic [7:0]    err_cnt
);

    localparam int AB   = width_to_bytes(AW);
    localparam int DB   = width_to_bytes(DW);
    localparam int MAXB = (AB > DB) ? AB : DB;
    localparam int IW   = $clog2(MAXB + 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          rd_q,    rd_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [3:0]    lat_q,   lat_d;
    logic [7:0]    err_q,   err_d;
`ifdef GHOSTBUS_BYTE_HOST_BURST_EN
    logic [3:0]    beats_q, beats_d;
`endif

    logic rx_acc;
    logic ser_load;
    logic ser_done;

    // Held low while reset is asserted so every output reads 0 during reset.
    assign rx_ready = !gb_rst && (state_q == IDLE || state_q == ADDR || state_q == WDATA);
    assign rx_acc   = rx_valid && rx_ready;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        idx_d    = idx_q;
        lat_d    = lat_q;
        err_d    = err_q;
        ser_load = 1'b0;
`ifdef GHOSTBUS_BYTE_HOST_BURST_EN
        beats_d  = beats_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_acc) begin
                    if (rx_data[CMD_RSV_MSB:CMD_RSV_LSB] != '0) begin
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    end else begin
                        rd_d    = rx_data[CMD_RD_BIT];
                        idx_d   = '0;
                        state_d = ADDR;
`ifdef GHOSTBUS_BYTE_HOST_BURST_EN
                        beats_d = rx_data[CMD_CNT_MSB:CMD_CNT_LSB];
`endif
                    end
                end
            end
            ADDR: begin
                if (rx_acc) begin
                    addr_d = (addr_q << 8) | AW'(rx_data);
                    idx_d  = idx_q + IW'(1);
                    if (idx_q == IW'(AB - 1)) begin
                        idx_d   = '0;
                        state_d = rd_q ? RSTB : WDATA;
                    end
                end
            end
            WDATA: begin
                if (rx_acc) begin
                    wdata_d = (wdata_q << 8) | DW'(rx_data);
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IW'(DB - 1)) begin
                        idx_d   = '0;
                        state_d = WSTB;
                    end
                end
            end
            WSTB: begin
`ifdef GHOSTBUS_BYTE_HOST_BURST_EN
                addr_d = addr_q + AW'(1);
                if (beats_q != 4'd0) begin
                    beats_d = beats_q - 4'd1;
                    state_d = WDATA;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            RSTB: begin
                lat_d   = 4'(RD_LAT);
                state_d = WAIT;
`ifdef GHOSTBUS_BYTE_HOST_BURST_EN
                addr_d  = addr_q + AW'(1);
`endif
            end
            WAIT: begin
                // Counter hits zero in the RD_LAT-th cycle after the strobe: sample rdata then.
                lat_d = lat_q - 4'd1;
                if (lat_q == 4'd1) begin
                    ser_load = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (ser_done) begin
`ifdef GHOSTBUS_BYTE_HOST_BURST_EN
                    if (beats_q != 4'd0) begin
                        beats_d = beats_q - 4'd1;
                        state_d = RSTB;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            idx_q   <= '0;
            lat_q   <= '0;
            err_q   <= '0;
`ifdef GHOSTBUS_BYTE_HOST_BURST_EN
            beats_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
`ifdef GHOSTBUS_BYTE_HOST_BURST_EN
            beats_q <= beats_d;
`endif
        end
    end

    ghostbus_byte_serializer #(.DW(DW)) u_ser (
        .gb_clk   (gb_clk),
        .gb_rst   (gb_rst),
        .load_vld (ser_load),
        .load_dat (gb_rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (ser_done)
    );

    assign gb_addr  = addr_q;
    assign gb_wdata = wdata_q;
    assign gb_wen   = (state_q == WSTB);
    assign gb_rstb  = (state_q == RSTB);
    assign busy     = (state_q != IDLE);
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_ghostbus_byte_host.sv
// Directed bench for ghostbus_byte_host: write, read, backpressure, reserved bytes, reset, burst.
module tb_ghostbus_byte_host;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int RD_LAT = 2;

    logic          gb_clk, gb_rst;
    logic [7:0]    rx_data;
    logic          rx_valid, rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid, tx_ready;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_wdata, gb_rdata;
    logic          gb_wen, gb_rstb, busy;
    logic [7:0]    err_cnt;

    int tests = 0;
    int fails = 0;

    ghostbus_byte_host #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .gb_clk(gb_clk), .gb_rst(gb_rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_rdata(gb_rdata),
        .gb_wen(gb_wen), .gb_rstb(gb_rstb), .busy(busy), .err_cnt(err_cnt)
    );

    initial begin
        gb_clk = 1'b0;
        forever #5 gb_clk = ~gb_clk;
    end

    // Bus model: read data is only valid in the cycle exactly RD_LAT after gb_rstb.
    logic [DW-1:0] rd_word;
    logic [RD_LAT-1:0] rstb_pipe;
    always @(posedge gb_clk or posedge gb_rst) begin
        if (gb_rst) rstb_pipe <= '0;
        else        rstb_pipe <= {rstb_pipe[RD_LAT-2:0], gb_rstb};
    end
    assign gb_rdata = rstb_pipe[RD_LAT-1] ? rd_word : 32'hA5A5A5A5;

    logic [AW-1:0] wq_a[$];
    logic [DW-1:0] wq_d[$];
    logic [7:0]    txq[$];
    int rstb_n, stall_err, rxrdy_err, both_err;
    logic          prev_stall;
    logic [7:0]    prev_dat;

    always @(negedge gb_clk) begin
        if (prev_stall && (!tx_valid || tx_data !== prev_dat)) stall_err++;
        prev_stall = tx_valid && !tx_ready;
        prev_dat   = tx_data;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (tx_valid && rx_ready) rxrdy_err++;
        if (gb_wen && gb_rstb) both_err++;
        if (gb_wen) begin
            wq_a.push_back(gb_addr);
            wq_d.push_back(gb_wdata);
        end
        if (gb_rstb) rstb_n++;
    end

    task automatic clear_mon();
        wq_a.delete(); wq_d.delete(); txq.delete();
        rstb_n = 0; stall_err = 0; rxrdy_err = 0; both_err = 0;
        prev_stall = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge gb_clk);
        while (!rx_ready && n < 200) begin
            @(negedge gb_clk);
            n++;
        end
        if (!rx_ready) begin
            tests++; fails++;
            $display("FAIL send_byte_timeout: rx_ready stayed %b, required 1", rx_ready);
        end
        @(posedge gb_clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge gb_clk);
        #1;
    endtask

    task automatic test_reset();
        gb_rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1; rd_word = '0;
        idle_cycles(3);
        tests++;
        if ({gb_wen, gb_rstb, tx_valid, busy, rx_ready} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: wen/rstb/txv/busy/rxr=%b, required 00000",
                     {gb_wen, gb_rstb, tx_valid, busy, rx_ready});
        end
        tests++;
        if (gb_addr !== '0 || gb_wdata !== '0 || err_cnt !== 8'd0 || tx_data !== 8'd0) begin
            fails++;
            $display("FAIL reset_data: addr=%h wdata=%h err=%h tx=%h, required all 0",
                     gb_addr, gb_wdata, err_cnt, tx_data);
        end
        gb_rst = 1'b0;
        idle_cycles(1);
        tests++;
        if (rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_rx_ready: got %b, required 1", rx_ready);
        end
        clear_mon();
    endtask

    task automatic test_write();
        clear_mon();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_word(32'hDEADBEEF);
        idle_cycles(8);
        tests++;
        if (wq_a.size() != 1) begin
            fails++;
            $display("FAIL write_count: %0d strobes, required 1", wq_a.size());
        end else begin
            tests++;
            if (wq_a[0] !== 24'h000010 || wq_d[0] !== 32'hDEADBEEF) begin
                fails++;
                $display("FAIL write_value: addr=%h data=%h, required 000010 DEADBEEF", wq_a[0], wq_d[0]);
            end
        end
        tests++;
        if (txq.size() != 0 || rstb_n != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL write_side: tx=%0d rstb=%0d busy=%b, required 0 0 0", txq.size(), rstb_n, busy);
        end
        tests++;
        if (gb_wdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL write_hold: wdata=%h, required DEADBEEF", gb_wdata);
        end
    endtask

    task automatic test_read();
        int n;
        clear_mon();
        rd_word  = 32'h12345678;
        tx_ready = 1'b1;
        send_byte(8'h80); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        n = 0;
        while (txq.size() < 4 && n < 50) begin idle_cycles(1); n++; end
        idle_cycles(4);
        tests++;
        if (txq.size() != 4) begin
            fails++;
            $display("FAIL read_count: %0d bytes, required 4", txq.size());
        end else begin
            tests++;
            if ({txq[0], txq[1], txq[2], txq[3]} !== 32'h12345678) begin
                fails++;
                $display("FAIL read_data: got %h, required 12345678", {txq[0], txq[1], txq[2], txq[3]});
            end
        end
        tests++;
        if (rstb_n != 1 || wq_a.size() != 0 || both_err != 0 || gb_addr !== 24'h000020) begin
            fails++;
            $display("FAIL read_strobes: rstb=%0d wen=%0d both=%0d addr=%h, required 1 0 0 000020",
                     rstb_n, wq_a.size(), both_err, gb_addr);
        end
    endtask

    task automatic test_backpressure();
        int n;
        clear_mon();
        rd_word  = 32'hA1B2C3D4;
        tx_ready = 1'b0;
        send_byte(8'h80); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        n = 0;
        while (txq.size() < 4 && n < 60) begin
            @(posedge gb_clk);
            #1 tx_ready = ~tx_ready;
            n++;
        end
        tx_ready = 1'b1;
        idle_cycles(4);
        tests++;
        if (txq.size() != 4) begin
            fails++;
            $display("FAIL bp_count: %0d bytes, required 4", txq.size());
        end else begin
            tests++;
            if ({txq[0], txq[1], txq[2], txq[3]} !== 32'hA1B2C3D4) begin
                fails++;
                $display("FAIL bp_data: got %h, required A1B2C3D4", {txq[0], txq[1], txq[2], txq[3]});
            end
        end
        tests++;
        if (stall_err != 0 || rxrdy_err != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_stable: stall_err=%0d rxrdy_err=%0d busy=%b, required 0 0 0",
                     stall_err, rxrdy_err, busy);
        end
    endtask

    task automatic test_reserved();
        clear_mon();
        send_byte(8'h30);
        idle_cycles(1);
        tests++;
        if (err_cnt !== 8'd1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rsv_first: err=%0d busy=%b, required 1 0", err_cnt, busy);
        end
        for (int i = 1; i < 300; i++) send_byte(8'h30);
        idle_cycles(2);
        tests++;
        if (err_cnt !== 8'd255 || wq_a.size() != 0 || rstb_n != 0) begin
            fails++;
            $display("FAIL rsv_sat: err=%0d wen=%0d rstb=%0d, required 255 0 0", err_cnt, wq_a.size(), rstb_n);
        end
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h44);
        send_word(32'h11223344);
        idle_cycles(6);
        tests++;
        if (wq_a.size() != 1 || wq_a[0] !== 24'h000044 || wq_d[0] !== 32'h11223344 || err_cnt !== 8'd255) begin
            fails++;
            $display("FAIL rsv_after_write: n=%0d err=%0d, required one write at 000044 of 11223344, err 255",
                     wq_a.size(), err_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        send_byte(8'h00); send_byte(8'hAB); send_byte(8'hCD);
        gb_rst = 1'b1;
        idle_cycles(2);
        tests++;
        if (busy !== 1'b0 || gb_addr !== '0 || err_cnt !== 8'd0) begin
            fails++;
            $display("FAIL midrst_state: busy=%b addr=%h err=%0d, required 0 0 0", busy, gb_addr, err_cnt);
        end
        gb_rst = 1'b0;
        idle_cycles(5);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h23);
        send_word(32'h55667788);
        idle_cycles(6);
        tests++;
        if (wq_a.size() != 1 || wq_a[0] !== 24'h000123 || wq_d[0] !== 32'h55667788) begin
            fails++;
            $display("FAIL midrst_write: n=%0d, required one write at 000123 of 55667788", wq_a.size());
        end
    endtask

`ifdef GHOSTBUS_BYTE_HOST_BURST_EN
    task automatic test_burst();
        logic [AW-1:0] exp_a[4];
        logic [DW-1:0] exp_d[4];
        clear_mon();
        exp_a = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
        exp_d = '{32'h0000AAAA, 32'h1111BBBB, 32'h2222CCCC, 32'h3333DDDD};
        send_byte(8'h03); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFE);
        for (int i = 0; i < 4; i++) send_word(exp_d[i]);
        idle_cycles(6);
        tests++;
        if (wq_a.size() != 4) begin
            fails++;
            $display("FAIL burst_count: %0d strobes, required 4", wq_a.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (wq_a[i] !== exp_a[i] || wq_d[i] !== exp_d[i]) begin
                    fails++;
                    $display("FAIL burst_beat%0d: addr=%h data=%h, required %h %h",
                             i, wq_a[i], wq_d[i], exp_a[i], exp_d[i]);
                end
            end
        end
    endtask
`else
    task automatic test_single_beat_cnt();
        clear_mon();
        send_byte(8'h0F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        send_word(32'h01020304);
        idle_cycles(8);
        tests++;
        if (wq_a.size() != 1 || busy !== 1'b0 || gb_addr !== 24'h000008 || wq_d[0] !== 32'h01020304) begin
            fails++;
            $display("FAIL cnt_ignored: n=%0d busy=%b addr=%h, required 1 0 000008", wq_a.size(), busy, gb_addr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_reserved();
        test_reset_midframe();
`ifdef GHOSTBUS_BYTE_HOST_BURST_EN
        test_burst();
`else
        test_single_beat_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
